// File: rtl/alu_seq_if.sv
// alu_seq_if: operand-issue and result-writeback valid/ready bundle for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 16);
   logic             in_valid, in_ready, out_valid, out_ready;
   logic             carry, zero, div_by_zero;
   logic [WIDTH-1:0] a, b, result;
   logic [3:0]       op;
   modport master (output in_valid, a, b, op, out_ready,
                   input  in_ready, out_valid, result, carry, zero, div_by_zero);
   modport slave  (input  in_valid, a, b, op, out_ready,
                   output in_ready, out_valid, result, carry, zero, div_by_zero);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops plus iterative shift-add multiply and restoring divide.
module alu_seq #(parameter int WIDTH = 16) (
   input logic     clk,
   input logic     reset,
   alu_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   localparam int CW = $clog2(WIDTH) + 1;
   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opd_q, res_q, res_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               carry_q, zero_q, dbz_q, carry_d, dbz_d;
   logic [WIDTH:0]     sum, dif, mul_sum, div_trial, div_dif;
   // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum = {1'b0, bus.a} + {1'b0, bus.b};
      dif = {1'b0, bus.a} - {1'b0, bus.b};
      res_d = '0;
      carry_d = 1'b0;
      dbz_d = 1'b0;
      case (bus.op)
         4'd0: {carry_d, res_d} = sum;
         4'd1: {carry_d, res_d} = dif;
         4'd3: begin res_d = '1; dbz_d = 1'b1; end
         4'd4: {carry_d, res_d} = {bus.b, 1'b0};
         4'd5: {res_d, carry_d} = {1'b0, bus.b};
         4'd6: res_d = {bus.b[WIDTH-2:0], bus.b[WIDTH-1]};
         4'd7: res_d = {bus.b[0], bus.b[WIDTH-1:1]};
         4'd8: res_d = bus.a & bus.b;
         4'd9: res_d = bus.a | bus.b;
         4'd10: res_d = bus.a ^ bus.b;
         4'd11: res_d = ~(bus.a | bus.b);
         4'd12: res_d = ~(bus.a & bus.b);
         4'd13: res_d = ~(bus.a ^ bus.b);
         4'd14: res_d = WIDTH'(bus.a > bus.b);
         4'd15: res_d = WIDTH'(bus.a == bus.b);
         default: res_d = '0;
      endcase
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_dif = div_trial - {1'b0, opd_q};
      acc_d = state_q == MUL ? {mul_sum, acc_q[WIDTH-1:1]}
            : div_dif[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
            : {div_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               cnt_q <= '0;
               opd_q <= bus.op == 4'd2 ? bus.a : bus.b;
               acc_q <= {{WIDTH{1'b0}}, bus.op == 4'd2 ? bus.b : bus.a};
               if (bus.op == 4'd2) state_q <= MUL;
               else if (bus.op == 4'd3 && bus.b != '0) state_q <= DIV;
               else begin
                  state_q <= DONE;
                  res_q   <= res_d;
                  carry_q <= carry_d;
                  zero_q  <= res_d == '0;
                  dbz_q   <= dbz_d;
               end
            end
            MUL, DIV: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= DONE;
                  res_q   <= acc_d[WIDTH-1:0];
                  carry_q <= state_q == MUL && |acc_d[2*WIDTH-1:WIDTH];
                  zero_q  <= acc_d[WIDTH-1:0] == '0;
                  dbz_q   <= 1'b0;
               end
            end
            DONE: if (bus.out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.in_ready    = state_q == IDLE;
   assign bus.out_valid   = state_q == DONE;
   assign bus.result      = res_q;
   assign bus.carry       = carry_q;
   assign bus.zero        = zero_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq at WIDTH 16 and 8 against an arithmetic model.
module tb_alu_seq;
   logic clk, reset;
   int   asserts = 0, failures = 0;
   alu_seq_if #(.WIDTH(16)) i16 ();
   alu_seq_if #(.WIDTH(8))  i8 ();
   alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(i16.slave));
   alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   // returns {div_by_zero, carry, result}
   function automatic logic [17:0] model(input int w, input longint unsigned a, input longint unsigned b, input int op);
      longint unsigned m = (64'd1 << w) - 1, r = 0, p;
      bit c = 0, d = 0;
      case (op)
         0: begin p = a + b; r = p & m; c = (p >> w) != 0; end
         1: begin r = (a - b) & m; c = a < b; end
         2: begin p = a * b; r = p & m; c = (p >> w) != 0; end
         3: if (b == 0) begin r = m; d = 1; end else r = a / b;
         4: begin r = (b * 2) & m; c = ((b >> (w - 1)) & 1) != 0; end
         5: begin r = b / 2; c = (b % 2) != 0; end
         6: r = ((b * 2) | (b >> (w - 1))) & m;
         7: r = (b >> 1) | ((b & 1) << (w - 1));
         8: r = a & b;
         9: r = a | b;
         10: r = a ^ b;
         11: r = ~(a | b) & m;
         12: r = ~(a & b) & m;
         13: r = ~(a ^ b) & m;
         14: r = a > b ? 1 : 0;
         default: r = a == b ? 1 : 0;
      endcase
      return {d, c, r[15:0]};
   endfunction
   task automatic run(input bit w8, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      output logic [15:0] r, output logic c, output logic z, output logic d, output int lat);
      @(negedge clk);
      if (w8) begin i8.a = a[7:0]; i8.b = b[7:0]; i8.op = op; i8.in_valid = 1; i8.out_ready = 1; end
      else begin i16.a = a; i16.b = b; i16.op = op; i16.in_valid = 1; i16.out_ready = 1; end
      @(posedge clk);
      lat = 1;
      #1;
      i8.in_valid = 0; i16.in_valid = 0;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i16.a = 16'($urandom); i16.b = 16'($urandom);
      while (!(w8 ? i8.out_valid : i16.out_valid) && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      r = w8 ? {8'h00, i8.result} : i16.result;
      c = w8 ? i8.carry : i16.carry;
      z = w8 ? i8.zero : i16.zero;
      d = w8 ? i8.div_by_zero : i16.div_by_zero;
      @(posedge clk); #1;
   endtask
   task automatic test_reset;
      asserts++;
      if ({i16.in_ready, i16.out_valid, i16.result, i16.carry, i16.zero, i16.div_by_zero} !== {2'b10, 19'd0}) begin
         failures++; $display("FAIL reset_release got rdy=%b vld=%b r=%h exp rdy=1 vld=0 r=0", i16.in_ready, i16.out_valid, i16.result);
      end
      @(negedge clk);
      i16.a = 16'h8000; i16.b = 16'h8001; i16.op = 4'd0; i16.in_valid = 1; i16.out_ready = 0;
      @(posedge clk); #1;
      i16.in_valid = 0;
      asserts++;
      if ({i16.out_valid, i16.result, i16.carry} !== {1'b1, 16'h0001, 1'b1}) begin
         failures++; $display("FAIL reset_pre_done got vld=%b r=%h c=%b exp vld=1 r=0001 c=1", i16.out_valid, i16.result, i16.carry);
      end
      #2 reset = 1;
      #1;
      asserts++;
      if ({i16.in_ready, i16.out_valid, i16.result, i16.carry, i16.zero, i16.div_by_zero} !== {2'b10, 19'd0}) begin
         failures++; $display("FAIL reset_async got rdy=%b vld=%b r=%h c=%b z=%b d=%b exp rdy=1 vld=0 r=0 c=0 z=0 d=0",
            i16.in_ready, i16.out_valid, i16.result, i16.carry, i16.zero, i16.div_by_zero);
      end
      @(negedge clk);
      reset = 0; i16.out_ready = 1;
   endtask
   task automatic test_add_sub;
      logic [15:0] r; logic c, z, d; int lat;
      run(0, 16'hFFFF, 16'h0001, 4'd0, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'h0000, 3'b110, 32'd1}) begin
         failures++; $display("FAIL add_carry got r=%h c=%b z=%b lat=%0d exp r=0000 c=1 z=1 lat=1", r, c, z, lat);
      end
      run(0, 16'd5, 16'd7, 4'd1, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'hFFFE, 3'b100, 32'd1}) begin
         failures++; $display("FAIL sub_borrow got r=%h c=%b z=%b lat=%0d exp r=fffe c=1 z=0 lat=1", r, c, z, lat);
      end
   endtask
   task automatic test_mul;
      logic [15:0] r; logic c, z, d; int lat;
      run(0, 16'h0100, 16'h0101, 4'd2, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'h0100, 3'b100, 32'd17}) begin
         failures++; $display("FAIL mul_ovf got r=%h c=%b lat=%0d exp r=0100 c=1 lat=17", r, c, lat);
      end
      run(0, 16'd300, 16'd200, 4'd2, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'hEA60, 3'b000, 32'd17}) begin
         failures++; $display("FAIL mul_plain got r=%h c=%b lat=%0d exp r=ea60 c=0 lat=17", r, c, lat);
      end
   endtask
   task automatic test_div;
      logic [15:0] r; logic c, z, d; int lat;
      run(0, 16'd1000, 16'd7, 4'd3, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'd142, 3'b000, 32'd17}) begin
         failures++; $display("FAIL div got r=%0d d=%b lat=%0d exp r=142 d=0 lat=17", r, d, lat);
      end
      run(0, 16'd1000, 16'd0, 4'd3, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'hFFFF, 3'b001, 32'd1}) begin
         failures++; $display("FAIL div_zero got r=%h c=%b d=%b lat=%0d exp r=ffff c=0 d=1 lat=1", r, c, d, lat);
      end
   endtask
   task automatic test_back_pressure;
      @(negedge clk);
      i16.a = 16'h1234; i16.b = 16'h1234; i16.op = 4'd15; i16.in_valid = 1; i16.out_ready = 0;
      @(posedge clk); #1;
      asserts++;
      if ({i16.out_valid, i16.in_ready, i16.result} !== {2'b10, 16'd1}) begin
         failures++; $display("FAIL bp_enter got vld=%b rdy=%b r=%h exp vld=1 rdy=0 r=0001", i16.out_valid, i16.in_ready, i16.result);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         i16.in_valid = ~i16.in_valid; i16.a = 16'($urandom); i16.b = 16'($urandom); i16.op = 4'($urandom);
         @(posedge clk); #1;
         asserts++;
         if ({i16.out_valid, i16.in_ready, i16.result, i16.carry, i16.zero} !== {2'b10, 16'd1, 2'b00}) begin
            failures++; $display("FAIL bp_hold[%0d] got vld=%b rdy=%b r=%h c=%b z=%b exp vld=1 rdy=0 r=0001 c=0 z=0",
               k, i16.out_valid, i16.in_ready, i16.result, i16.carry, i16.zero);
         end
      end
      @(negedge clk);
      i16.out_ready = 1; i16.in_valid = 0;
      @(posedge clk); #1;
      asserts++;
      if ({i16.in_ready, i16.out_valid} !== 2'b10) begin
         failures++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", i16.in_ready, i16.out_valid);
      end
      repeat (3) begin
         @(posedge clk); #1;
         asserts++;
         if (i16.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_single_result got vld=%b exp vld=0", i16.out_valid);
         end
      end
   endtask
   task automatic test_reset_mid_op;
      logic [15:0] r; logic c, z, d; int lat, seen = 0;
      @(negedge clk);
      i16.a = 16'h00FF; i16.b = 16'h0033; i16.op = 4'd2; i16.in_valid = 1; i16.out_ready = 1;
      @(posedge clk); #1;
      i16.in_valid = 0;
      repeat (6) @(posedge clk);
      @(negedge clk) reset = 1;
      @(negedge clk) reset = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (i16.out_valid) seen++;
      end
      asserts++;
      if (seen !== 0) begin
         failures++; $display("FAIL reset_mid_mul got %0d out_valid cycles exp 0", seen);
      end
      run(0, 16'd2, 16'd3, 4'd0, r, c, z, d, lat);
      asserts++;
      if ({r, c, z, d, lat} !== {16'd5, 3'b000, 32'd1}) begin
         failures++; $display("FAIL add_after_reset got r=%0d lat=%0d exp r=5 lat=1", r, lat);
      end
   endtask
   task automatic test_back_to_back;
      logic [17:0] q[$];
      logic [17:0] e;
      logic [3:0]  op;
      bit          was_ready;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         op = 4'($urandom);
         if (op == 4'd2 || op == 4'd3) op = op + 4'd8;
         i16.a = 16'($urandom); i16.b = 16'($urandom); i16.op = op; i16.in_valid = 1; i16.out_ready = 1;
         was_ready = i16.in_ready;
         if (was_ready) q.push_back(model(16, i16.a, i16.b, int'(op)));
         @(posedge clk); #1;
         asserts++;
         if (i16.out_valid !== was_ready) begin
            failures++; $display("FAIL b2b_valid[%0d] got vld=%b exp vld=%b", k, i16.out_valid, was_ready);
         end
         if (i16.out_valid && q.size() > 0) begin
            e = q.pop_front();
            asserts++;
            if ({i16.carry, i16.result} !== e[16:0]) begin
               failures++; $display("FAIL b2b_result[%0d] got c=%b r=%h exp c=%b r=%h", k, i16.carry, i16.result, e[16], e[15:0]);
            end
         end
      end
      @(negedge clk) i16.in_valid = 0;
      repeat (2) @(posedge clk);
   endtask
   task automatic test_width8;
      logic [15:0] r; logic c, z, d; int lat;
      logic [3:0]  ops [3] = '{4'd6, 4'd7, 4'd4};
      logic [8:0]  exp [3] = '{9'h003, 9'h0C0, 9'h102};
      for (int k = 0; k < 3; k++) begin
         run(1, 16'h5A, 16'h81, ops[k], r, c, z, d, lat);
         asserts++;
         if ({c, r[7:0], lat} !== {exp[k], 32'd1}) begin
            failures++; $display("FAIL w8_shift op=%0d got c=%b r=%h lat=%0d exp c=%b r=%h lat=1", ops[k], c, r[7:0], lat, exp[k][8], exp[k][7:0]);
         end
      end
   endtask
   task automatic test_random(input bit w8, input int n);
      logic [15:0] r, a, b; logic c, z, d; int lat, w, el;
      logic [17:0] e;
      logic [3:0]  op;
      w = w8 ? 8 : 16;
      for (int k = 0; k < n; k++) begin
         a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
         if (w8) begin a[15:8] = 0; b[15:8] = 0; end
         if ($urandom_range(0, 9) == 0) b = 0;
         if ($urandom_range(0, 9) == 0) a = b;
         e = model(w, a, b, int'(op));
         el = (op == 4'd2 || (op == 4'd3 && b != 0)) ? w + 1 : 1;
         run(w8, a, b, op, r, c, z, d, lat);
         asserts++;
         if ({d, c, z, r, lat} !== {e[17:16], e[15:0] == 16'd0, e[15:0], el}) begin
            failures++; $display("FAIL rand_w%0d op=%0d a=%h b=%h got r=%h c=%b z=%b d=%b lat=%0d exp r=%h c=%b z=%b d=%b lat=%0d",
               w, op, a, b, r, c, z, d, lat, e[15:0], e[16], e[15:0] == 16'd0, e[17], el);
         end
      end
   endtask
   initial begin
      reset = 1;
      {i16.in_valid, i16.out_ready, i16.a, i16.b, i16.op} = '0;
      {i8.in_valid, i8.out_ready, i8.a, i8.b, i8.op} = '0;
      repeat (2) @(negedge clk);
      reset = 0;
      #1;
      test_reset;
      test_add_sub;
      test_mul;
      test_div;
      test_back_pressure;
      test_reset_mid_op;
      test_back_to_back;
      test_width8;
      test_random(0, 80);
      test_random(1, 60);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end
endmodule
